// File: rtl/baud_gen_frac.sv
// Fractional-N baud generator. It divides clk down to an oversample strobe, using
// a phase accumulator to stretch some periods by one clock. It also produces the
// mid-bit and bit-boundary strobes and accepts divisor updates only at bit boundaries.
module baud_gen_frac #(
   parameter int unsigned DIV_W    = 16,
   parameter int unsigned FRAC_W   = 4,
   parameter int unsigned OS_RATE  = 16,
   parameter int unsigned DEF_INT  = 78,
   parameter int unsigned DEF_FRAC = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   input  logic                       cfg_valid,
   input  logic [DIV_W-1:0]           cfg_int,
   input  logic [FRAC_W-1:0]          cfg_frac,
   output logic                       cfg_ready,
   output logic                       os_tick,
   output logic                       mid_tick,
   output logic                       bit_tick,
   output logic [$clog2(OS_RATE)-1:0] os_cnt
);

   localparam int unsigned OS_W  = $clog2(OS_RATE);
   localparam int unsigned CNT_W = DIV_W + 1;
   localparam logic [OS_W-1:0]  OS_LAST = OS_W'(OS_RATE - 1);
   localparam logic [OS_W-1:0]  OS_MID  = OS_W'(OS_RATE / 2 - 1);
   localparam logic [DIV_W-1:0] INT_MIN = DIV_W'(2);

   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] acc_q, acc_d;
   logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
   logic [DIV_W-1:0]  int_q, int_d;
   logic [FRAC_W-1:0] frac_q, frac_d;
   logic              os_tick_q, os_tick_d;
   logic              mid_tick_q, mid_tick_d;
   logic              bit_tick_q, bit_tick_d;

   logic [FRAC_W:0]   acc_sum;
   logic [DIV_W-1:0]  int_eff;
   logic [CNT_W-1:0]  period;
   logic              fire;
   logic              load;

   // Divisor updates are only safe when idle or right at a bit boundary.
   assign cfg_ready = !en || bit_tick_q;

   // Next-state: divider counter, phase accumulator, oversample index, divisor load.
   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      os_cnt_d   = os_cnt_q;
      int_d      = int_q;
      frac_d     = frac_q;
      os_tick_d  = 1'b0;
      mid_tick_d = 1'b0;
      bit_tick_d = 1'b0;

      acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
      int_eff = (int_q < INT_MIN) ? INT_MIN : int_q;
      period  = CNT_W'(int_eff) + CNT_W'(acc_sum[FRAC_W]);
      fire    = en && (cnt_q >= period);
      load    = cfg_valid && cfg_ready;

      if (!en) begin
         cnt_d    = '0;
         acc_d    = '0;
         os_cnt_d = '0;
      end else begin
         // The counter restarts at 1 after a strobe, so the first period after
         // enable, which counts from 0, also lasts exactly 'period' clocks.
         if (fire) begin
            cnt_d      = CNT_W'(1);
            acc_d      = acc_sum[FRAC_W-1:0];
            os_tick_d  = 1'b1;
            mid_tick_d = (os_cnt_q == OS_MID);
            bit_tick_d = (os_cnt_q == OS_LAST);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
         // The index of an interval stays visible through its closing strobe.
         if (os_tick_q) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
         end
      end

      // A load wins over an enable drop and restarts the fractional phase.
      if (load) begin
         int_d  = cfg_int;
         frac_d = cfg_frac;
         acc_d  = '0;
      end
   end

   // State registers with synchronous reset to the default divisor.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         os_cnt_q   <= '0;
         int_q      <= DIV_W'(DEF_INT);
         frac_q     <= FRAC_W'(DEF_FRAC);
         os_tick_q  <= 1'b0;
         mid_tick_q <= 1'b0;
         bit_tick_q <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         os_cnt_q   <= os_cnt_d;
         int_q      <= int_d;
         frac_q     <= frac_d;
         os_tick_q  <= os_tick_d;
         mid_tick_q <= mid_tick_d;
         bit_tick_q <= bit_tick_d;
      end
   end

   assign os_tick  = os_tick_q;
   assign mid_tick = mid_tick_q;
   assign bit_tick = bit_tick_q;
   assign os_cnt   = os_cnt_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Testbench for baud_gen_frac. Expected strobe times, indices and flags come from
// the divisor arithmetic and are queued, then popped as the DUT issues each os_tick.
module tb_baud_gen_frac;

   localparam int DIV_W   = 16;
   localparam int FRAC_W  = 4;
   localparam int OS_RATE = 16;

   logic              clk;
   logic              rst;
   logic              en;
   logic              cfg_valid;
   logic [DIV_W-1:0]  cfg_int;
   logic [FRAC_W-1:0] cfg_frac;
   logic              cfg_ready;
   logic              os_tick;
   logic              mid_tick;
   logic              bit_tick;
   logic [3:0]        os_cnt;

   baud_gen_frac dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .cfg_valid (cfg_valid),
      .cfg_int   (cfg_int),
      .cfg_frac  (cfg_frac),
      .cfg_ready (cfg_ready),
      .os_tick   (os_tick),
      .mid_tick  (mid_tick),
      .bit_tick  (bit_tick),
      .os_cnt    (os_cnt)
   );

   typedef struct {
      int t;
      int os;
      int mid;
      int bt;
   } exp_t;

   typedef struct {
      int ci;
      int cf;
      int total16;
   } vec_t;

   exp_t sb[$];
   int   seen[$];
   int   cyc;
   int   n_cmp;
   int   n_bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle number: after rising edge n, cyc == n.
   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every os_tick must match the head of the expectation queue.
   always @(negedge clk) begin
      exp_t e;
      if (os_tick === 1'b1) begin
         seen.push_back(cyc);
         if (sb.size() == 0) begin
            check("unexpected_os_tick", 1, 0);
         end else begin
            e = sb.pop_front();
            check("tick_time", cyc, e.t);
            check("tick_os_cnt", int'(os_cnt), e.os);
            check("tick_mid", int'(mid_tick), e.mid);
            check("tick_bit", int'(bit_tick), e.bt);
         end
      end else if (mid_tick === 1'b1 || bit_tick === 1'b1) begin
         check("stray_mid_or_bit", 1, 0);
      end
   end

   // Queue n strobes for a period stream starting at edge 'base' with acc=0, os_cnt=0.
   task automatic gen(input int base, input int iv, input int fv, input int n, output int last);
      int acc;
      int os;
      int t;
      int s;
      int p;
      exp_t e;
      acc = 0;
      os  = 0;
      t   = base;
      for (int i = 0; i < n; i++) begin
         s = acc + fv;
         p = ((iv < 2) ? 2 : iv) + (s >> FRAC_W);
         t = t + p;
         e.t   = t;
         e.os  = os;
         e.mid = (os == OS_RATE / 2 - 1) ? 1 : 0;
         e.bt  = (os == OS_RATE - 1) ? 1 : 0;
         sb.push_back(e);
         acc = s % (1 << FRAC_W);
         os  = (os + 1) % OS_RATE;
      end
      last = t;
   endtask

   // Advance to just after the falling edge; the monitor has already run.
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_left(input int left, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (sb.size() <= left) break;
         step();
      end
      if (sb.size() > left) begin
         check("wait_timeout", sb.size(), left);
         sb.delete();
      end
   endtask

   task automatic load_idle(input int ci, input int cf);
      step();
      en        = 1'b0;
      cfg_valid = 1'b1;
      cfg_int   = DIV_W'(ci);
      cfg_frac  = FRAC_W'(cf);
      #1;
      check("cfg_ready_idle", int'(cfg_ready), 1);
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic enable_run(input int ci, input int cf, input int n, output int e_edge, output int last);
      seen.delete();
      en     = 1'b1;
      e_edge = cyc + 1;
      gen(e_edge, ci, cf, n, last);
   endtask

   initial begin
      vec_t tbl[6];
      int   e_edge;
      int   last;
      int   t_bit;
      int   got_ready;

      tbl[0] = '{ci: 10, cf: 0,  total16: 160};
      tbl[1] = '{ci: 1,  cf: 0,  total16: 32};
      tbl[2] = '{ci: 0,  cf: 0,  total16: 32};
      tbl[3] = '{ci: 5,  cf: 8,  total16: 88};
      tbl[4] = '{ci: 3,  cf: 15, total16: 63};
      tbl[5] = '{ci: 2,  cf: 1,  total16: 33};

      n_cmp     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      en        = 1'b1;
      cfg_valid = 1'b1;
      cfg_int   = DIV_W'(5);
      cfg_frac  = FRAC_W'(3);

      // Reset overrides en and cfg_valid.
      step();
      step();
      check("rst_os_tick", int'(os_tick), 0);
      check("rst_mid_tick", int'(mid_tick), 0);
      check("rst_bit_tick", int'(bit_tick), 0);
      check("rst_os_cnt", int'(os_cnt), 0);
      check("rst_cfg_ready_en1", int'(cfg_ready), 0);

      // Defaults: 78 + 2/16 -> 1250 clocks per 16 strobes.
      rst       = 1'b0;
      cfg_valid = 1'b0;
      seen.delete();
      e_edge = cyc + 1;
      gen(e_edge, 78, 2, 32, last);
      wait_left(0, 3000);
      if (seen.size() >= 32) begin
         check("default_first16", seen[15] - e_edge, 1250);
         check("default_second16", seen[31] - seen[15], 1250);
      end else begin
         check("default_tick_count", seen.size(), 32);
      end

      // Table of divisors loaded while idle.
      foreach (tbl[k]) begin
         load_idle(tbl[k].ci, tbl[k].cf);
         enable_run(tbl[k].ci, tbl[k].cf, 16, e_edge, last);
         wait_left(0, 400);
         if (seen.size() >= 16) begin
            check($sformatf("total16_int%0d_frac%0d", tbl[k].ci, tbl[k].cf),
                  seen[15] - e_edge, tbl[k].total16);
         end else begin
            check("table_tick_count", seen.size(), 16);
         end
      end

      // Mid-bit cfg_valid: accepted only at the bit boundary; the old period holds until then.
      load_idle(10, 0);
      enable_run(10, 0, 16, e_edge, t_bit);
      wait_left(11, 200);
      cfg_valid = 1'b1;
      cfg_int   = DIV_W'(6);
      cfg_frac  = FRAC_W'(0);
      got_ready = 0;
      for (int i = 0; i < 300; i++) begin
         #1;
         check("cfg_ready_midbit", int'(cfg_ready), (cyc == t_bit) ? 1 : 0);
         if (cfg_ready) begin
            got_ready = 1;
            break;
         end
         step();
      end
      check("cfg_ready_seen", got_ready, 1);
      step();
      cfg_valid = 1'b0;
      if (got_ready == 1) gen(t_bit, 6, 0, 16, last);
      wait_left(0, 300);

      // Enable dropped inside interval 9, then raised 5 clocks later.
      load_idle(10, 0);
      enable_run(10, 0, 16, e_edge, last);
      wait_left(7, 200);
      step();
      step();
      step();
      check("os_cnt_before_drop", int'(os_cnt), 9);
      en = 1'b0;
      sb.delete();
      for (int i = 0; i < 5; i++) begin
         step();
         check("dis_os_tick", int'(os_tick), 0);
         check("dis_bit_tick", int'(bit_tick), 0);
         check("dis_os_cnt", int'(os_cnt), 0);
      end
      enable_run(10, 0, 16, e_edge, last);
      wait_left(0, 300);

      // Reset mid-bit after a custom load restores the default divisor.
      load_idle(7, 5);
      enable_run(7, 5, 16, e_edge, last);
      wait_left(10, 200);
      step();
      step();
      rst       = 1'b1;
      cfg_valid = 1'b1;
      cfg_int   = DIV_W'(3);
      sb.delete();
      step();
      check("rst2_os_tick", int'(os_tick), 0);
      check("rst2_mid_tick", int'(mid_tick), 0);
      check("rst2_bit_tick", int'(bit_tick), 0);
      check("rst2_os_cnt", int'(os_cnt), 0);
      check("rst2_cfg_ready", int'(cfg_ready), 0);
      rst       = 1'b0;
      cfg_valid = 1'b0;
      seen.delete();
      e_edge = cyc + 1;
      gen(e_edge, 78, 2, 16, last);
      wait_left(0, 1500);
      if (seen.size() >= 16) begin
         check("post_rst_first16", seen[15] - e_edge, 1250);
      end else begin
         check("post_rst_tick_count", seen.size(), 16);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/baud_gen_frac.md
BAUD_GEN_FRAC -- requirements
Module: baud_gen_frac

Parameters
REQ-001 SHALL have parameter DIV_W, default 16: width of the integer divisor.
REQ-002 SHALL have parameter FRAC_W, default 4: width of the fractional divisor.
REQ-003 SHALL have parameter OS_RATE, default 16: oversample ticks per bit; even, at least 4.
REQ-004 SHALL have parameter DEF_INT, default 78, and DEF_FRAC, default 2: divisor after reset (12 MHz clk, 9600 baud x16).

Interface
REQ-005 SHALL have port clk, input, 1 bit: system clock; the only clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port en, input, 1 bit: generator enable.
REQ-008 SHALL have port cfg_valid, input, 1 bit: new divisor offered.
REQ-009 SHALL have port cfg_int, input, DIV_W bits: integer part of the oversample period, in clk cycles.
REQ-010 SHALL have port cfg_frac, input, FRAC_W bits: fractional part of the oversample period, in units of 1/2^FRAC_W cycle.
REQ-011 SHALL have port cfg_ready, output, 1 bit: divisor load accepted this cycle.
REQ-012 SHALL have port os_tick, output, 1 bit: one-cycle oversample strobe.
REQ-013 SHALL have port mid_tick, output, 1 bit: one-cycle strobe at the mid-bit sample point.
REQ-014 SHALL have port bit_tick, output, 1 bit: one-cycle strobe at the bit boundary.
REQ-015 SHALL have port os_cnt, output, clog2(OS_RATE) bits: current oversample index within the bit.

Function
REQ-016 SHALL hold a divider counter, a FRAC_W-bit phase accumulator, os_cnt, and active divisor registers INT and FRAC.
REQ-017 SHALL, when en=0, clear the divider counter, accumulator and os_cnt every cycle, and drive all strobes 0.
REQ-018 SHALL make each oversample period P = INT + c clocks, where c = carry-out of (acc + FRAC), evaluated at the start of that period.
REQ-019 SHALL, at the end of each period, update acc to (acc + FRAC) mod 2^FRAC_W.
REQ-020 SHALL assert os_tick for exactly one clk at the end of each period, and first assert it P clocks after the first rising edge at which en is sampled 1.
REQ-021 SHALL advance os_cnt on each os_tick, wrapping from OS_RATE-1 to 0.
REQ-022 SHALL assert bit_tick coincident with the os_tick at which os_cnt = OS_RATE-1.
REQ-023 SHALL assert mid_tick coincident with the os_tick at which os_cnt = OS_RATE/2-1.
REQ-024 SHALL keep the average oversample period equal to INT + FRAC/2^FRAC_W clocks exactly over every 2^FRAC_W periods.
REQ-025 SHALL treat INT values 0 and 1 as 2: minimum period 2 clocks, no stuck or continuous os_tick.
REQ-026 SHALL drive cfg_ready = (!en) || bit_tick, combinationally from registered state.
REQ-027 SHALL load cfg_int/cfg_frac into INT/FRAC on a cycle with cfg_valid && cfg_ready.
REQ-028 SHALL clear acc on that load, with the new divisor governing the next period; the current bit is never retimed.
REQ-029 SHALL make cfg_valid without cfg_ready a no-op; the requester holds it until accepted.
REQ-030 SHALL, on en deassertion mid-bit, abandon the partial bit; on reassertion, restart at os_cnt=0 with a full period (REQ-020).
REQ-031 SHALL give the load priority when en falls in the same cycle as an accepted load.

Reset
REQ-032 SHALL, on rst=1 at a clk edge, set INT=DEF_INT, FRAC=DEF_FRAC, and clear counter, acc and os_cnt.
REQ-033 SHALL, on rst=1 at a clk edge, drive os_tick, mid_tick and bit_tick 0.
REQ-034 SHALL make rst override en and cfg_valid, and behave identically when asserted mid-bit.

Verification
REQ-035 SHALL cover: reset, en=1 with defaults -> os_tick spacing pattern 78,78,...,79 (two 79s per 16 periods), 1250 clks per 16 os_ticks; bit_tick every 16 os_ticks, ±1 clk.
REQ-036 SHALL cover: cfg_int=10, cfg_frac=0 loaded with en=0 -> os_tick every 10 clks; mid_tick at os_cnt 7; bit_tick every 160 clks.
REQ-037 SHALL cover: cfg_valid raised mid-bit -> cfg_ready only on the bit_tick cycle, and the old period is held until that boundary.
REQ-038 SHALL cover: cfg_int=1 -> period 2 clks; cfg_int=0 -> period 2 clks.
REQ-039 SHALL cover: en dropped at os_cnt=9, then raised 5 clks later -> strobes 0 while low, first os_tick INT clks after re-enable, os_cnt from 0.
REQ-040 SHALL cover: rst pulsed mid-bit after a custom load -> defaults restored, and all outputs 0 the following cycle.
